// File: rtl/instr_encoder_loader_if.sv
// Field-intake handshake and instruction-memory write bus for the encoder/loader.
// The slave modport is the loader's view; master is the field producer plus the memory.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [25:0]       in_target;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_target, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_target, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes field tuples into ISA words and writes them to sequential memory addresses via a small FIFO.
// Word reaches mem_wdata one cycle after acceptance; in_ready drops when the FIFO is full, mem side holds while mem_ready is low.
module instr_encoder_loader #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     num_words,
  instr_encoder_loader_if.slave bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W:0]     words_written
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]    DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]    ONE_OCC   = 1;
  localparam logic [PTR_W-1:0]  ONE_PTR   = 1;
  localparam logic [ADDR_W:0]   ONE_CNT   = 1;
  localparam logic [ADDR_W-1:0] ONE_ADDR  = 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   num_q, num_d;
  logic [ADDR_W:0]   acc_q, acc_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              err_q, err_d;
  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic [31:0]       fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W:0]    cnt_q, cnt_d;

  logic        fifo_empty, fifo_full;
  logic        in_rdy, push, pop;
  logic [31:0] enc_word;

  always_comb begin
    enc_word = '0;
    case (bus.in_kind)
      2'd0:    enc_word = {6'b100000, bus.in_rs, bus.in_rt, bus.in_rd, 11'b0};
      2'd1:    enc_word = {6'b100010, bus.in_rs, bus.in_rt, bus.in_rd, 11'b0};
      2'd2:    enc_word = {6'b000010, bus.in_target};
      default: enc_word = '0;
    endcase
  end

  // Full is the registered occupancy, so a same-cycle pop never frees a slot early.
  assign fifo_empty    = (cnt_q == '0);
  assign fifo_full     = (cnt_q == DEPTH_CNT);
  assign pop           = !fifo_empty && bus.mem_ready;
  assign bus.mem_we    = !fifo_empty;
  assign bus.mem_addr  = wr_ptr_q;
  assign bus.mem_wdata = fifo_empty ? '0 : fifo_q[head_q];
  assign bus.in_ready  = in_rdy;
  assign busy          = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;
  assign words_written = words_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    num_d    = num_q;
    acc_d    = acc_q;
    words_d  = words_q;
    err_d    = err_q;
    fifo_d   = fifo_q;
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    in_rdy   = 1'b0;
    push     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          wr_ptr_d = base_addr;
          num_d    = num_words;
          acc_d    = '0;
          words_d  = '0;
          err_d    = 1'b0;
          state_d  = (num_words == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        in_rdy = !fifo_full && (acc_q < num_q);
        if (bus.in_valid && in_rdy) begin
          acc_d = acc_q + ONE_CNT;
          if (bus.in_kind == 2'd3) begin
            err_d = 1'b1;
          end else begin
            push = 1'b1;
          end
          if (acc_q + ONE_CNT == num_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (fifo_empty) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      fifo_d[tail_q] = enc_word;
      tail_d         = tail_q + ONE_PTR;
    end
    if (pop) begin
      head_d   = head_q + ONE_PTR;
      wr_ptr_d = wr_ptr_q + ONE_ADDR;
      words_d  = words_q + ONE_CNT;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + ONE_OCC;
      2'b01:   cnt_d = cnt_q - ONE_OCC;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      num_q    <= '0;
      acc_q    <= '0;
      words_q  <= '0;
      err_q    <= 1'b0;
      fifo_q   <= '{default: '0};
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      num_q    <= num_d;
      acc_q    <= acc_d;
      words_q  <= words_d;
      err_q    <= err_d;
      fifo_q   <= fifo_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Producer end of the instruction-word interface: accepts decoded instruction fields (kind, rs, rt, rd, jump target) over a valid/ready handshake.
- Packs each accepted instruction into a 32-bit word using the team's ISA encoding and writes the words sequentially into instruction memory, starting at a programmed base address.
- A small FIFO decouples field intake from memory-write backpressure.
- Used by the test/boot loader to populate instruction memory before the core runs.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- FIFO_DEPTH, 4, encoded-word buffer depth; power of two, >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- base_addr  in  ADDR_W  first write address, latched on start.
- num_words  in  ADDR_W+1  instructions to accept, latched on start.
- in_valid  in  1  field tuple valid.
- in_ready  out  1  block accepts the tuple this cycle.
- in_kind  in  2  0=ADD, 1=SUB, 2=J, 3=illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_target  in  26  jump target.
- mem_we  out  1  write request.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  encoded word.
- busy  out  1  high in LOAD or DRAIN.
- done  out  1  high in DONE; held until the next start.
- err  out  1  sticky: an illegal kind was accepted during this load.
- words_written  out  ADDR_W+1  count of completed memory writes this load.

Behaviour:
- Reset (async, immediate): state=IDLE; FIFO emptied; all outputs 0, including mem_we, in_ready, done, err, words_written, mem_addr and mem_wdata.
- Encoding:
  - ADD: {6'b100000, rs, rt, rd, 11'b0}.
  - SUB: {6'b100010, rs, rt, rd, 11'b0}.
  - J: {6'b000010, target}.
  - Kind 3: no word is pushed; err sets; the tuple still counts toward num_words.
- States:
  - IDLE: in_ready=0. On start, latch base_addr and num_words, clear err and words_written. Go to DONE if num_words==0, else LOAD.
  - LOAD: in_ready = (FIFO not full) && (accepted < num_words). "Full" is evaluated before any same-cycle pop (conservative). On in_valid&&in_ready, encode combinationally and push; accepted++. When accepted reaches num_words, go to DRAIN.
  - DRAIN: in_ready=0. When the FIFO is empty and no write is pending, go to DONE.
  - DONE: done=1; in_ready=0. On start, behave as in IDLE and clear done.
- start is ignored in LOAD and DRAIN.
- Write side (LOAD/DRAIN):
  - mem_we = FIFO not empty; mem_wdata = FIFO head; mem_addr = write pointer.
  - On mem_we&&mem_ready: pop, write pointer +1 (wraps mod 2^ADDR_W), words_written +1.
  - While mem_we is high and mem_ready is low, mem_addr and mem_wdata hold stable.
- Latency: an accepted tuple appears on mem_wdata no earlier than the following cycle. With mem_ready held high, sustained throughput is one word per cycle.
- A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- Invariants:
  - words_written equals num_words minus the number of illegal tuples at DONE.
  - Writes never go past the last accepted word.
- Reset asserted mid-load aborts the load. No further writes occur after reset; memory contents already written are not touched.

Test Plan:
- base=0x10, num=3; ADD(1,2,3), SUB(4,5,6), J(0x10); mem_ready=1 -> writes 0x80221800@0x10, 0x88853000@0x11, 0x08000010@0x12; done=1, words_written=3, err=0.
- base=0xFE, num=3, three ADD(0,0,0) -> addresses 0xFE, 0xFF, 0x00 (wrap), each data 0x80000000.
- mem_ready=0 for 10 cycles, in_valid held high, num=8 -> in_ready drops after 4 accepts; mem_addr/mem_wdata stable while stalled; after release, all 8 words written in order.
- num=2: kind=3, then ADD(1,2,3) -> err=1, one write of 0x80221800 at base, words_written=1, done=1.
- num_words=0 with start -> DONE on the next cycle; in_ready and mem_we never assert.
- Assert rst_n=0 after 2 of 5 words are written -> mem_we, busy, done and err drop immediately; no further writes; state IDLE after release; a new start runs normally.
